// File: rtl/lif_tdm_scheduler_if.sv
// Datapath link between the TDM scheduler (master) and the shared synapse+LIF datapath (slave).
// Signal suffixes are from the scheduler's point of view.
interface lif_tdm_scheduler_if #(
    parameter int IDX_W = 2,
    parameter int DW    = 8
);
    logic             dp_valid_o;
    logic             dp_ready_i;
    logic [IDX_W-1:0] dp_idx_o;
    logic [DW-1:0]    dp_current_o;
    logic [DW-1:0]    dp_state_o;
    logic             dp_done_i;
    logic [DW-1:0]    dp_state_i;
    logic             dp_spike_i;

    modport master (
        output dp_valid_o, dp_idx_o, dp_current_o, dp_state_o,
        input  dp_ready_i, dp_done_i, dp_state_i, dp_spike_i
    );

    modport slave (
        input  dp_valid_o, dp_idx_o, dp_current_o, dp_state_o,
        output dp_ready_i, dp_done_i, dp_state_i, dp_spike_i
    );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-division scheduler sharing one synapse+LIF datapath across NUM_NEURONS virtual
// neurons: holds weights and membrane states, walks the neurons once per step, publishes spikes.
module lif_tdm_scheduler #(
    parameter int            NUM_NEURONS = 4,
    parameter int            IDX_W       = 2,
    parameter int            DW          = 8,
    parameter logic [DW-1:0] WEIGHT_INIT = DW'(2)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   step_i,
    input  logic [DW-1:0]          data_i,
    input  logic                   cfg_we_i,
    input  logic [IDX_W-1:0]       cfg_idx_i,
    input  logic [DW-1:0]          cfg_weight_i,
    lif_tdm_scheduler_if.master    dp,
    output logic                   busy_o,
    output logic                   step_done_o,
    output logic [NUM_NEURONS-1:0] spikes_o,
    output logic [1:0]             err_o,
    output logic [2:0]             dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DW-1:0]          data_q;
    logic [DW-1:0]          weight_q [NUM_NEURONS];
    logic [DW-1:0]          mem_q    [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] acc_q;
    logic [NUM_NEURONS-1:0] acc_d;
    logic [NUM_NEURONS-1:0] spikes_q;
    logic [1:0]             err_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DW-1:0]          cap_state_q;
    logic                   cap_spike_q;
    logic [2*DW-1:0]        prod;

    // Handshake: a request transfers on the edge where dp_valid_o && dp_ready_i; idx, current
    // and state come straight from registers that do not change while the request is pending.
    assign prod            = {{DW{1'b0}}, data_q} * {{DW{1'b0}}, weight_q[idx_q]};
    assign dp.dp_valid_o   = valid_q;
    assign dp.dp_idx_o     = idx_q;
    assign dp.dp_current_o = (|prod[2*DW-1:DW]) ? {DW{1'b1}} : prod[DW-1:0];
    assign dp.dp_state_o   = mem_q[idx_q];

    assign busy_o      = busy_q;
    assign step_done_o = done_q;
    assign spikes_o    = spikes_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    // Accumulator including the spike being written back, so the last neuron lands in spikes_o.
    always_comb begin
        acc_d        = acc_q;
        acc_d[idx_q] = cap_spike_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            acc_q       <= '0;
            spikes_q    <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_state_q <= '0;
            cap_spike_q <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight_q[i] <= WEIGHT_INIT;
                mem_q[i]    <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (busy_q && step_i) begin
                err_q[0] <= 1'b1;
            end
            if (busy_q && cfg_we_i) begin
                err_q[1] <= 1'b1;
            end
            // Weights only change while idle, so a step always sees one consistent set.
            if (!busy_q && cfg_we_i) begin
                weight_q[cfg_idx_i] <= cfg_weight_i;
            end

            case (state_q)
                S_IDLE: begin
                    if (step_i) begin
                        data_q  <= data_i;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dp.dp_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dp.dp_done_i) begin
                        cap_state_q <= dp.dp_state_i;
                        cap_spike_q <= dp.dp_spike_i;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_q[idx_q] <= cap_state_q;
                    acc_q        <= acc_d;
                    if (idx_q == LAST) begin
                        spikes_q <= acc_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
